// File: rtl/echo_request_deserializer.sv
// echo_request_deserializer: assembles host words (header + LEN payload words) into tagged echo messages; LEN!=2 messages are drained and dropped (ECHO_DESER_ERRCNT_EN adds a saturating drop counter).
// Latency: header accepted cycle N, payloads N+1/N+2, enq__ENA earliest in cycle N+3; peak one message per 4 cycles.
// Backpressure: in__RDY drops only while a complete message waits in FULL for enq__RDY; it depends on registered state only.
`timescale 1ns/1ps
module echo_request_deserializer #(
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 16,
    parameter int LEN_WIDTH  = 16
`ifdef ECHO_DESER_ERRCNT_EN
    ,
    parameter int ERR_WIDTH  = 8
`endif
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic                  in__ENA,
    input  logic [DATA_WIDTH-1:0] in__data,
    output logic                  in__RDY,
    output logic                  enq__ENA,
    input  logic                  enq__RDY,
    output logic [TAG_WIDTH-1:0]  enq__v__tag,
    output logic [DATA_WIDTH-1:0] enq__v__data__heard__meth,
    output logic [DATA_WIDTH-1:0] enq__v__data__heard__v
`ifdef ECHO_DESER_ERRCNT_EN
    ,
    output logic [ERR_WIDTH-1:0]  drop_count
`endif
);

    typedef enum logic [2:0] {
        S_HDR   = 3'd0,
        S_PAY0  = 3'd1,
        S_PAY1  = 3'd2,
        S_DRAIN = 3'd3,
        S_FULL  = 3'd4
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic                  accept;
    logic [TAG_WIDTH-1:0]  hdr_tag;
    logic [LEN_WIDTH-1:0]  hdr_len;
    logic [LEN_WIDTH-1:0]  remaining;

    // Ready is a function of the registered state; held low while reset is asserted.
    assign in__RDY  = nRST && (state != S_FULL);
    assign accept   = in__ENA && in__RDY;
    assign enq__ENA = (state == S_FULL) && enq__RDY;
    assign hdr_tag  = in__data[DATA_WIDTH-1 -: TAG_WIDTH];
    assign hdr_len  = in__data[LEN_WIDTH-1:0];

    // State register.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= S_HDR;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: header length selects assemble, silent drop (LEN 0) or drain.
    always_comb begin
        state_nxt = state;
        case (state)
            S_HDR: begin
                if (accept) begin
                    if (hdr_len == LEN_WIDTH'(2)) begin
                        state_nxt = S_PAY0;
                    end else if (hdr_len == '0) begin
                        state_nxt = S_HDR;
                    end else begin
                        state_nxt = S_DRAIN;
                    end
                end
            end
            S_PAY0:  if (accept) state_nxt = S_PAY1;
            S_PAY1:  if (accept) state_nxt = S_FULL;
            S_DRAIN: if (accept && (remaining == LEN_WIDTH'(1))) state_nxt = S_HDR;
            S_FULL:  if (enq__ENA) state_nxt = S_HDR;
            default: state_nxt = S_HDR;
        endcase
    end

    // Message registers: only accepted words update them, so they hold in FULL.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            enq__v__tag               <= '0;
            enq__v__data__heard__meth <= '0;
            enq__v__data__heard__v    <= '0;
            remaining                 <= '0;
        end else if (accept) begin
            case (state)
                S_HDR: begin
                    enq__v__tag <= hdr_tag;
                    if ((hdr_len != '0) && (hdr_len != LEN_WIDTH'(2))) begin
                        remaining <= hdr_len;
                    end
                end
                S_PAY0:  enq__v__data__heard__meth <= in__data;
                S_PAY1:  enq__v__data__heard__v    <= in__data;
                S_DRAIN: remaining <= remaining - LEN_WIDTH'(1);
                default: ;
            endcase
        end
    end

`ifdef ECHO_DESER_ERRCNT_EN
    logic hdr_drop;
    assign hdr_drop = accept && (state == S_HDR) && (hdr_len != LEN_WIDTH'(2));

    // Drop counter: one count per malformed header, saturating, cleared only by reset.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            drop_count <= '0;
        end else if (hdr_drop && (drop_count != '1)) begin
            drop_count <= drop_count + ERR_WIDTH'(1);
        end
    end
`endif

endmodule

// File: tb/tb_echo_request_deserializer.sv
`timescale 1ns/1ps
module tb_echo_request_deserializer;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        in_ena = 1'b0;
    logic [31:0] in_data = 32'h0;
    logic        enq_rdy = 1'b0;
    wire         in_rdy;
    wire         enq_ena;
    wire  [15:0] tag;
    wire  [31:0] meth;
    wire  [31:0] v;
`ifdef ECHO_DESER_ERRCNT_EN
    wire  [7:0]  drop_count;
`endif

    echo_request_deserializer dut (
        .CLK                       (CLK),
        .nRST                      (nRST),
        .in__ENA                   (in_ena),
        .in__data                  (in_data),
        .in__RDY                   (in_rdy),
        .enq__ENA                  (enq_ena),
        .enq__RDY                  (enq_rdy),
        .enq__v__tag               (tag),
        .enq__v__data__heard__meth (meth),
        .enq__v__data__heard__v    (v)
`ifdef ECHO_DESER_ERRCNT_EN
        ,
        .drop_count                (drop_count)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [15:0] tag;
        logic [31:0] meth;
        logic [31:0] v;
    } msg_t;

    msg_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   drops    = 0;
    int   xfers    = 0;
    int   cyc      = 0;
    bit   rand_rdy = 1'b0;

    always @(posedge CLK) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Scoreboard monitor: every transfer pops the oldest expected message.
    always @(negedge CLK) begin
        if (nRST) begin
            if (!enq_rdy) check("enq_ena_without_rdy", 64'(enq_ena), 64'd0);
            if (enq_ena) begin
                xfers++;
                if (exp_q.size() == 0) begin
                    check("unexpected_transfer", 64'(exp_q.size()), 64'd1);
                end else begin
                    msg_t e;
                    e = exp_q.pop_front();
                    check("msg_tag", 64'(tag), 64'(e.tag));
                    check("msg_meth", 64'(meth), 64'(e.meth));
                    check("msg_v", 64'(v), 64'(e.v));
                end
            end
        end
    end

    // Random downstream backpressure when enabled.
    initial begin
        forever begin
            @(posedge CLK);
            #2;
            if (rand_rdy) enq_rdy = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    // All tasks are entered and left at 1ns after a rising edge.
    task automatic send_word(input logic [31:0] w);
        int guard;
        guard = 0;
        while (!in_rdy && guard < 300) begin
            @(posedge CLK); #1;
            guard++;
        end
        if (!in_rdy) begin
            check("in_rdy_timeout", 64'(in_rdy), 64'd1);
        end else begin
            in_ena  = 1'b1;
            in_data = w;
            @(posedge CLK); #1;
            in_ena  = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge CLK); #1; end
    endtask

    // Reference model: only LEN==2 yields a message; anything else counts one drop.
    task automatic send_msg(input logic [15:0] t, input logic [15:0] len,
                            input logic [31:0] p0, input logic [31:0] p1, input int gap_max);
        msg_t m;
        if (len == 16'd2) begin
            m.tag = t; m.meth = p0; m.v = p1;
            exp_q.push_back(m);
        end else begin
            drops++;
        end
        send_word({t, len});
        for (int i = 0; i < int'(len); i++) begin
            if (gap_max > 0) idle($urandom_range(0, gap_max));
            send_word(i == 0 ? p0 : (i == 1 ? p1 : $urandom));
        end
    endtask

    task automatic wait_empty();
        int guard;
        guard = 0;
        while ((exp_q.size() != 0) && guard < 200) begin
            idle(1);
            guard++;
        end
        check("queue_drained", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic check_drops();
`ifdef ECHO_DESER_ERRCNT_EN
        check("drop_count", 64'(drop_count), 64'(drops > 255 ? 255 : drops));
`endif
    endtask

    initial begin
        int c0;
        int x0;
        // Reset state.
        idle(2);
        check("rst_in_rdy", 64'(in_rdy), 64'd0);
        check("rst_enq_ena", 64'(enq_ena), 64'd0);
        check("rst_tag", 64'(tag), 64'd0);
        check("rst_meth", 64'(meth), 64'd0);
        check("rst_v", 64'(v), 64'd0);
        nRST = 1'b1;
        #1;
        check("post_rst_in_rdy", 64'(in_rdy), 64'd1);
        check_drops();
        idle(1);

        // 1: basic message with latency.
        enq_rdy = 1'b1;
        send_msg(16'd1, 16'd2, 32'hAAAA_0001, 32'h5555_0002, 0);
        check("t1_enq_ena_at_n3", 64'(enq_ena), 64'd1);
        check("t1_in_rdy_full", 64'(in_rdy), 64'd0);
        idle(1);
        check("t1_enq_ena_after", 64'(enq_ena), 64'd0);
        check("t1_in_rdy_after", 64'(in_rdy), 64'd1);

        // 2: downstream stall holds the message stable.
        enq_rdy = 1'b0;
        x0 = xfers;
        send_msg(16'd1, 16'd2, 32'hAAAA_0001, 32'h5555_0002, 0);
        for (int i = 0; i < 5; i++) begin
            check("t2_in_rdy_stall", 64'(in_rdy), 64'd0);
            check("t2_enq_ena_stall", 64'(enq_ena), 64'd0);
            check("t2_tag_stable", 64'(tag), 64'd1);
            check("t2_meth_stable", 64'(meth), 64'h0000_0000_AAAA_0001);
            check("t2_v_stable", 64'(v), 64'h0000_0000_5555_0002);
            idle(1);
        end
        enq_rdy = 1'b1;
        #1;
        check("t2_enq_ena_release", 64'(enq_ena), 64'd1);
        @(posedge CLK); #1;
        check("t2_in_rdy_next", 64'(in_rdy), 64'd1);
        check("t2_single_xfer", 64'(xfers - x0), 64'd1);

        // 3: LEN 3 drained, next message forwarded.
        send_msg(16'd1, 16'd3, 32'h1111_1111, 32'h2222_2222, 0);
        send_msg(16'd2, 16'd2, 32'hCAFE_0000, 32'h0000_BEEF, 0);
        wait_empty();
        check_drops();

        // 4: LEN 0 header dropped, following word is a header; counter saturates.
        send_msg(16'd7, 16'd0, 32'h0, 32'h0, 0);
        send_msg(16'd9, 16'd2, 32'h0BAD_F00D, 32'h1234_5678, 0);
        wait_empty();
        check_drops();
`ifdef ECHO_DESER_ERRCNT_EN
        for (int i = 0; i < 256; i++) send_msg(16'd7, 16'd0, 32'h0, 32'h0, 0);
        check("t4_drop_saturated", 64'(drop_count), 64'hFF);
`endif

        // 5: reset in the middle of a message discards it.
        x0 = xfers;
        send_word({16'd3, 16'd2});
        send_word(32'hDEAD_0000);
        #2;
        nRST = 1'b0;
        #1;
        check("t5_rst_in_rdy", 64'(in_rdy), 64'd0);
        check("t5_rst_tag", 64'(tag), 64'd0);
        check("t5_rst_meth", 64'(meth), 64'd0);
        drops = 0;
        check_drops();
        @(posedge CLK); #1;
        nRST = 1'b1;
        #1;
        check("t5_in_rdy_release", 64'(in_rdy), 64'd1);
        idle(1);
        send_msg(16'd4, 16'd2, 32'h4444_0000, 32'h0000_4444, 0);
        wait_empty();
        check("t5_one_xfer", 64'(xfers - x0), 64'd1);

        // 6: 10 back-to-back messages in 40 cycles.
        idle(1);
        c0 = cyc;
        x0 = xfers;
        for (int k = 0; k < 10; k++) send_msg(16'(k + 16), 16'd2, $urandom, $urandom, 0);
        @(posedge CLK); #1;
        check("t6_cycles", 64'(cyc - c0), 64'd40);
        check("t6_xfers", 64'(xfers - x0), 64'd10);
        wait_empty();

        // 7: randomized traffic with random gaps and backpressure.
        rand_rdy = 1'b1;
        for (int k = 0; k < 150; k++) begin
            logic [15:0] len;
            int r;
            r = $urandom_range(0, 9);
            if (r < 6) len = 16'd2;
            else if (r == 6) len = 16'd0;
            else if (r == 7) len = 16'd1;
            else len = 16'($urandom_range(3, 4));
            send_msg(16'($urandom), len, $urandom, $urandom, 2);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        rand_rdy = 1'b0;
        enq_rdy = 1'b1;
        wait_empty();
        check_drops();

        idle(2);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
